load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sequential memory-access stage upstream of mem_extension.
- Accepts a load/store request from the execute stage and performs one handshaked transaction on the 64-bit data-memory port.
- Performs byte-lane alignment, strobe generation, misalignment detection and response timeout.
- Produces the right-aligned, unextended load value (mem_value) and the funct3 code (sel_mem_extension) that mem_extension consumes.

Parameters:
- ADDR_WIDTH, 64, width of request/memory address.
- TIMEOUT_CYCLES, 256, maximum cycles spent in WAIT_RSP before aborting with resp_timeout.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  execute-stage request valid
- req_ready  out  1  unit can accept a request (high only in IDLE)
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3; [1:0] = size (0 B, 1 H, 2 W, 3 D), [2] = unsigned (loads only)
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  64  store data, right-aligned
- resp_valid  out  1  one-cycle response pulse
- mem_value  out  64  load data shifted right by offset*8, upper bytes unmasked; 0 for stores/errors
- sel_mem_extension  out  3  latched req_funct3, valid with resp_valid
- resp_misaligned  out  1  access aborted, address not size-aligned
- resp_timeout  out  1  access aborted, no memory response in time
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_WIDTH  req_addr with [2:0] cleared
- mem_wdata  out  64  store data shifted left by offset*8
- mem_wstrb  out  8  byte strobes; 0 for loads
- mem_rsp_valid  in  1  read data / write ack valid
- mem_rdata  in  64  raw 64-bit memory word

Behaviour:
- Reset: state IDLE; every output 0 except req_ready = 1; timeout counter 0; latched registers 0. Reset mid-transaction abandons it; no response is issued.
- offset = req_addr[2:0]; size bytes = 1 << funct3[1:0].
- Misaligned when offset is not a multiple of the size bytes (H: offset[0]; W: offset[1:0]; D: offset[2:0] nonzero).
- IDLE: req_ready = 1.
  - On req_valid, latch write, funct3, offset, aligned address, shifted wdata and wstrb.
  - If misaligned, go to DONE with misaligned flag set; no memory access.
  - Otherwise go to REQ.
- REQ: mem_req_valid = 1; mem_addr, mem_we, mem_wdata and mem_wstrb are held stable until mem_req_ready. On handshake go to WAIT_RSP and clear the counter.
- WAIT_RSP:
  - On mem_rsp_valid, latch mem_value = mem_rdata >> (offset*8) for loads, 0 for stores; go to DONE.
  - Else increment the counter. When counter == TIMEOUT_CYCLES-1 without a response, go to DONE with timeout flag set.
  - If mem_rsp_valid arrives in the same cycle as the timeout, the response wins.
- DONE: resp_valid = 1 for exactly one cycle with mem_value, sel_mem_extension and flags; then IDLE. No response back-pressure.
- Minimum latency: request accepted at edge N, REQ at N+1; with ready and response immediate, resp_valid is high in cycle N+3. Misaligned: resp_valid in cycle N+1.
- Store strobes: B 0x01, H 0x03, W 0x0F, D 0xFF, each shifted left by offset. funct3[2] is ignored for stores.
- Any mem_rsp_valid outside WAIT_RSP is ignored.
- req_valid outside IDLE is ignored; the requester must hold it until req_ready.

Decomposition:
- Shared package lsu_pkg holds:
  - state_t enum {IDLE, REQ, WAIT_RSP, DONE}
  - size localparams (SIZE_B/H/W/D)
  - funct3 constants matching mem_extension's encoding
  - strobe base-mask function
- One combinational sub-module, store_align, takes offset, size and wdata and produces mem_wdata and mem_wstrb.
- The load right-shift stays inline.

Test Plan:
- Load word, funct3 010, addr 0x1004, mem_rdata 0x89ABCDEF_01234567, ready and response immediate:
  - mem_addr 0x1000, wstrb 0x00.
  - resp_valid 3 cycles after accept, mem_value 0x00000000_89ABCDEF upper bytes as shifted (0x00000000_89ABCDEF), sel_mem_extension 010.
- Store byte, funct3 000, addr 0x2003, wdata 0xAB:
  - mem_wdata 0x00000000_AB000000, wstrb 0x08, mem_we 1.
  - resp mem_value 0, no flags.
- Load halfword, addr 0x3001: resp_valid the next cycle with resp_misaligned = 1, mem_req_valid never asserted.
- mem_req_ready held low 5 cycles: mem_req_valid, mem_addr and mem_wdata stay stable all 5 cycles; the transaction completes after ready rises.
- No mem_rsp_valid with TIMEOUT_CYCLES=8: resp_timeout pulses with resp_valid after 8 WAIT_RSP cycles, then req_ready = 1.
- reset asserted during WAIT_RSP:
  - next cycle IDLE, req_ready 1, all other outputs 0.
  - a later stray mem_rsp_valid produces no resp_valid.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, access sizes,
// funct3 codes as consumed by mem_extension, and byte-lane helpers.
package lsu_pkg;

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_t;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
    localparam logic [1:0] SIZE_D = 2'd3;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    function automatic logic [7:0] strb_base(input logic [1:0] size);
        logic [7:0] mask;
        case (size)
            SIZE_B:  mask = 8'h01;
            SIZE_H:  mask = 8'h03;
            SIZE_W:  mask = 8'h0f;
            default: mask = 8'hff;
        endcase
        return mask;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] offset, input logic [1:0] size);
        logic mis;
        case (size)
            SIZE_B:  mis = 1'b0;
            SIZE_H:  mis = offset[0];
            SIZE_W:  mis = |offset[1:0];
            default: mis = |offset;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/store_align.sv
// Places right-aligned store data onto its byte lanes within the 64-bit
// memory word and produces the matching byte strobes.
module store_align
    import lsu_pkg::*;
(
    input  logic [2:0]  offset,
    input  logic [1:0]  size,
    input  logic [63:0] wdata,
    output logic [63:0] wdata_aligned,
    output logic [7:0]  wstrb
);

    always_comb begin
        wdata_aligned = wdata << {offset, 3'b000};
        wstrb         = strb_base(size) << offset;
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: one handshaked transaction per request on the 64-bit
// data port, with alignment, misalignment abort and response timeout.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 64,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [63:0]           req_wdata,
    output logic                  resp_valid,
    output logic [63:0]           mem_value,
    output logic [2:0]            sel_mem_extension,
    output logic                  resp_misaligned,
    output logic                  resp_timeout,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [63:0]           mem_wdata,
    output logic [7:0]            mem_wstrb,
    input  logic                  mem_rsp_valid,
    input  logic [63:0]           mem_rdata
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t                state_q, state_d;
    logic                  we_q, we_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [2:0]            offset_q, offset_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [63:0]           wdata_q, wdata_d;
    logic [7:0]            wstrb_q, wstrb_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [63:0]           value_q, value_d;
    logic                  misal_q, misal_d;
    logic                  tmo_q, tmo_d;

    logic [63:0] align_wdata;
    logic [7:0]  align_wstrb;
    logic        req_misaligned;

    store_align u_store_align (
        .offset        (req_addr[2:0]),
        .size          (req_funct3[1:0]),
        .wdata         (req_wdata),
        .wdata_aligned (align_wdata),
        .wstrb         (align_wstrb)
    );

    always_comb begin
        req_misaligned = is_misaligned(req_addr[2:0], req_funct3[1:0]);

        state_d  = state_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        offset_d = offset_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        cnt_d    = cnt_q;
        value_d  = value_q;
        misal_d  = misal_q;
        tmo_d    = tmo_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d     = req_write;
                    funct3_d = req_funct3;
                    offset_d = req_addr[2:0];
                    addr_d   = {req_addr[ADDR_WIDTH-1:3], 3'b000};
                    wdata_d  = align_wdata;
                    wstrb_d  = req_write ? align_wstrb : 8'h00;
                    value_d  = '0;
                    misal_d  = req_misaligned;
                    tmo_d    = 1'b0;
                    state_d  = req_misaligned ? DONE : REQ;
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    cnt_d   = '0;
                    state_d = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                // A response in the final counted cycle still beats the timeout.
                if (mem_rsp_valid) begin
                    value_d = we_q ? 64'd0 : (mem_rdata >> {offset_q, 3'b000});
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    tmo_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            funct3_q <= '0;
            offset_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            cnt_q    <= '0;
            value_q  <= '0;
            misal_q  <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            offset_q <= offset_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            cnt_q    <= cnt_d;
            value_q  <= value_d;
            misal_q  <= misal_d;
            tmo_q    <= tmo_d;
        end
    end

    // Memory and response fields are driven only while their valid is high.
    always_comb begin
        req_ready         = (state_q == IDLE);
        mem_req_valid     = (state_q == REQ);
        mem_we            = mem_req_valid & we_q;
        mem_addr          = mem_req_valid ? addr_q : '0;
        mem_wdata         = mem_req_valid ? wdata_q : 64'd0;
        mem_wstrb         = mem_req_valid ? wstrb_q : 8'h00;
        resp_valid        = (state_q == DONE);
        mem_value         = resp_valid ? value_q : 64'd0;
        sel_mem_extension = resp_valid ? funct3_q : 3'b000;
        resp_misaligned   = resp_valid & misal_q;
        resp_timeout      = resp_valid & tmo_q;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases followed by random
// transactions against an arithmetic reference model with a reactive memory.
module tb_load_store_unit;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr, req_wdata;
    logic        resp_valid;
    logic [63:0] mem_value;
    logic [2:0]  sel_mem_extension;
    logic        resp_misaligned, resp_timeout;
    logic        mem_req_valid, mem_req_ready, mem_we;
    logic [63:0] mem_addr, mem_wdata;
    logic [7:0]  mem_wstrb;
    logic        mem_rsp_valid;
    logic [63:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    load_store_unit #(
        .ADDR_WIDTH     (64),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_write         (req_write),
        .req_funct3        (req_funct3),
        .req_addr          (req_addr),
        .req_wdata         (req_wdata),
        .resp_valid        (resp_valid),
        .mem_value         (mem_value),
        .sel_mem_extension (sel_mem_extension),
        .resp_misaligned   (resp_misaligned),
        .resp_timeout      (resp_timeout),
        .mem_req_valid     (mem_req_valid),
        .mem_req_ready     (mem_req_ready),
        .mem_we            (mem_we),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .mem_wstrb         (mem_wstrb),
        .mem_rsp_valid     (mem_rsp_valid),
        .mem_rdata         (mem_rdata)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_idle(input string tag);
        check({tag, " req_ready"}, 64'(req_ready), 64'd1);
        check({tag, " resp_valid"}, 64'(resp_valid), 64'd0);
        check({tag, " mem_value"}, mem_value, 64'd0);
        check({tag, " sel"}, 64'(sel_mem_extension), 64'd0);
        check({tag, " flags"}, 64'({resp_misaligned, resp_timeout}), 64'd0);
        check({tag, " mem_req_valid"}, 64'(mem_req_valid), 64'd0);
        check({tag, " mem_we"}, 64'(mem_we), 64'd0);
        check({tag, " mem_addr"}, mem_addr, 64'd0);
        check({tag, " mem_wdata"}, mem_wdata, 64'd0);
        check({tag, " mem_wstrb"}, 64'(mem_wstrb), 64'd0);
    endtask

    // rsp_dly: WAIT_RSP cycles before the memory answers; >= T means never.
    task automatic run_txn(input logic w, input logic [2:0] f3, input logic [63:0] a,
                           input logic [63:0] wd, input logic [63:0] rd,
                           input int rdy_dly, input int rsp_dly);
        int          off, bytes;
        logic        mis, tmo;
        logic [7:0]  base, exp_strb;
        logic [63:0] exp_addr, exp_wd, exp_val;
        off      = int'(a[2:0]);
        bytes    = 1 << f3[1:0];
        mis      = (off % bytes) != 0;
        tmo      = !mis && (rsp_dly >= T);
        base     = 8'((1 << bytes) - 1);
        exp_strb = w ? base << off : 8'h00;
        exp_addr = a - 64'(off);
        exp_wd   = wd << (8 * off);
        exp_val  = (w || mis || tmo) ? 64'd0 : rd >> (8 * off);

        check("accept req_ready", 64'(req_ready), 64'd1);
        req_valid  = 1'b1;
        req_write  = w;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        step();
        // Scramble the request bus to show the unit latched it.
        req_valid  = 1'b0;
        req_write  = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = {$urandom, $urandom};
        req_wdata  = {$urandom, $urandom};

        if (!mis) begin
            for (int i = 0; i <= rdy_dly; i++) begin
                mem_req_ready = (i == rdy_dly);
                mem_rsp_valid = 1'($urandom);
                mem_rdata     = {$urandom, $urandom};
                check("req mem_req_valid", 64'(mem_req_valid), 64'd1);
                check("req mem_addr", mem_addr, exp_addr);
                check("req mem_we", 64'(mem_we), 64'(w));
                check("req mem_wdata", mem_wdata, exp_wd);
                check("req mem_wstrb", 64'(mem_wstrb), 64'(exp_strb));
                check("req resp_valid", 64'(resp_valid), 64'd0);
                step();
            end
            mem_req_ready = 1'b0;
            for (int j = 0; j < T; j++) begin
                mem_rsp_valid = (j == rsp_dly);
                mem_rdata     = (j == rsp_dly) ? rd : {$urandom, $urandom};
                check("wait mem_req_valid", 64'(mem_req_valid), 64'd0);
                check("wait resp_valid", 64'(resp_valid), 64'd0);
                step();
                if (j == rsp_dly) break;
            end
            mem_rsp_valid = 1'b0;
        end

        check("resp_valid", 64'(resp_valid), 64'd1);
        check("mem_value", mem_value, exp_val);
        check("sel_mem_extension", 64'(sel_mem_extension), 64'(f3));
        check("resp_misaligned", 64'(resp_misaligned), 64'(mis));
        check("resp_timeout", 64'(resp_timeout), 64'(tmo));
        check("resp mem_req_valid", 64'(mem_req_valid), 64'd0);
        step();
        check("after req_ready", 64'(req_ready), 64'd1);
        check("after resp_valid", 64'(resp_valid), 64'd0);
    endtask

    initial begin
        reset         = 1'b1;
        req_valid     = 1'b0;
        req_write     = 1'b0;
        req_funct3    = 3'b000;
        req_addr      = 64'd0;
        req_wdata     = 64'd0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rdata     = 64'd0;
        step();
        step();
        check_all_idle("reset");
        reset = 1'b0;
        step();
        check_all_idle("post-reset");

        // Load word, immediate ready and response.
        run_txn(1'b0, 3'b010, 64'h1004, 64'd0, 64'h89AB_CDEF_0123_4567, 0, 0);
        // Store byte into lane 3.
        run_txn(1'b1, 3'b000, 64'h2003, 64'hAB, 64'h0, 0, 0);
        // Misaligned halfword load.
        run_txn(1'b0, 3'b001, 64'h3001, 64'd0, 64'h0, 0, 0);
        // Ready held low for 5 cycles.
        run_txn(1'b1, 3'b011, 64'h4008, 64'h1122_3344_5566_7788, 64'h0, 5, 1);
        // No response: timeout.
        run_txn(1'b0, 3'b011, 64'h5000, 64'd0, 64'h0, 0, T);
        // Response in the timeout cycle wins.
        run_txn(1'b0, 3'b101, 64'h6006, 64'd0, 64'hDEAD_BEEF_CAFE_F00D, 1, T - 1);
        // Misaligned doubleword store.
        run_txn(1'b1, 3'b011, 64'h7004, 64'h55, 64'h0, 0, 0);

        // Reset while waiting for a response abandons the access.
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_funct3 = 3'b011;
        req_addr   = 64'h8000;
        step();
        req_valid     = 1'b0;
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_all_idle("mid-reset");
        mem_rsp_valid = 1'b1;
        mem_rdata     = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int k = 0; k < 3; k++) begin
            step();
            check("stray rsp resp_valid", 64'(resp_valid), 64'd0);
            check("stray rsp req_ready", 64'(req_ready), 64'd1);
        end
        mem_rsp_valid = 1'b0;

        for (int n = 0; n < 150; n++) begin
            logic [63:0] a;
            a = {$urandom, $urandom};
            run_txn(1'($urandom), 3'($urandom), a, {$urandom, $urandom},
                    {$urandom, $urandom}, int'($urandom_range(0, 3)),
                    int'($urandom_range(0, T + 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
